// File: rtl/fadd_issue_ctrl.sv
// Issue/collect wrapper around the fixed-latency fadd pipeline: credit-limited issue,
// valid/tag tracking and an in-order result FIFO. Optional FADD_OVF_STICKY_EN adds ovf_clr/ovf_sticky.
module fadd_issue_ctrl #(
  parameter int LATENCY    = 2,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  input  logic [31:0]      fadd_y,
  input  logic             fadd_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
`ifdef FADD_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [LATENCY:0] stg_valid;
  logic [TAG_W-1:0] stg_tag [0:LATENCY];

  logic             cap_valid;
  logic [31:0]      cap_y;
  logic             cap_ovf;
  logic [TAG_W-1:0] cap_tag;

  logic [31:0]      mem_y   [0:FIFO_DEPTH-1];
  logic             mem_ovf [0:FIFO_DEPTH-1];
  logic [TAG_W-1:0] mem_tag [0:FIFO_DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The capture stage holds a result on its way into the FIFO, so it consumes a credit too.
  always_comb begin
    used = 32'(count) + 32'(cap_valid);
    for (int unsigned i = 0; i <= LATENCY; i++) begin
      used = used + 32'(stg_valid[i]);
    end
  end

  assign in_ready = !rst && (used < 32'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = cap_valid;
  assign pop      = out_valid && out_ready;
  assign busy     = (stg_valid != '0) || cap_valid || (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fadd_x1 <= '0;
      fadd_x2 <= '0;
    end else if (accept) begin
      fadd_x1 <= in_x1;
      fadd_x2 <= {in_x2[31] ^ in_sub, in_x2[30:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
    end else begin
      stg_valid <= {stg_valid[LATENCY-1:0], accept};
    end
    stg_tag[0] <= in_tag;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      stg_tag[i] <= stg_tag[i-1];
    end
  end

  // fadd_y/fadd_ovf belong to the op sitting in the last tracking stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= stg_valid[LATENCY];
    end
    cap_y   <= fadd_y;
    cap_ovf <= fadd_ovf;
    cap_tag <= stg_tag[LATENCY];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_y[wr_ptr]   <= cap_y;
        mem_ovf[wr_ptr] <= cap_ovf;
        mem_tag[wr_ptr] <= cap_tag;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_y     = out_valid ? mem_y[rd_ptr]   : '0;
  assign out_ovf   = out_valid ? mem_ovf[rd_ptr] : 1'b0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr] : '0;

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(FIFO_DEPTH))));

`ifdef FADD_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (pop && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl; fadd is modelled as a LATENCY-deep pipe over a table of known sums.
module tb_fadd_issue_ctrl;

  localparam int LAT = 2;
  localparam int TW  = 5;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_x1;
  logic [31:0]   in_x2;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic [31:0]   fadd_x1;
  logic [31:0]   fadd_x2;
  logic [31:0]   fadd_y;
  logic          fadd_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic          out_ovf;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef FADD_OVF_STICKY_EN
  logic          ovf_clr;
  logic          ovf_sticky;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fadd_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_sub(in_sub), .in_tag(in_tag),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y), .fadd_ovf(fadd_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag),
`ifdef FADD_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
`endif
    .busy(busy)
  );

  // IEEE single results for the operand pairs used here; x + (+0) = x for the finite values issued.
  function automatic logic [32:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0)                                  return {1'b0, a};
    if (a == 32'h3f800000 && b == 32'h40000000)      return {1'b0, 32'h40400000};
    if (a == 32'h40a00000 && b == 32'hc0000000)      return {1'b0, 32'h40400000};
    if (a == 32'h7f7fffff && b == 32'h7f7fffff)      return {1'b1, 32'h7f800000};
    return {1'b0, 32'hffffffff};
  endfunction

  logic [32:0] fpipe [0:LAT-1];
  always @(posedge clk) begin
    fpipe[0] <= fmodel(fadd_x1, fadd_x2);
    for (int k = 1; k < LAT; k++) fpipe[k] <= fpipe[k-1];
  end
  assign {fadd_ovf, fadd_y} = fpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [TW-1:0] t);
    in_valid = 1'b1; in_x1 = a; in_x2 = b; in_sub = s; in_tag = t;
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n, acc, got, sent, cyc, seen;
    rst = 1'b1; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b0;
`ifdef FADD_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fadd_x1", fadd_x1, 0);
    chk("rst_out_y", out_y, 0);
`ifdef FADD_OVF_STICKY_EN
    chk("rst_sticky", ovf_sticky, 0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // single add with latency measurement and hold under backpressure
    send(32'h3f800000, 32'h40000000, 1'b0, 5'd5);
    chk("add_fadd_x1", fadd_x1, 32'h3f800000);
    chk("add_fadd_x2", fadd_x2, 32'h40000000);
    chk("add_busy", busy, 1);
    wait_result(n);
    chk("add_latency", n, LAT + 2);
    chk("add_y", out_y, 32'h40400000);
    chk("add_ovf", out_ovf, 0);
    chk("add_tag", out_tag, 5);
    tick();
    chk("add_hold_valid", out_valid, 1);
    chk("add_hold_y", out_y, 32'h40400000);
    pop_one();
    chk("add_popped", out_valid, 0);
    chk("add_idle_busy", busy, 0);

    // subtract: sign of x2 flipped on the way into fadd
    send(32'h40a00000, 32'h40000000, 1'b1, 5'd7);
    chk("sub_fadd_x2", fadd_x2, 32'hc0000000);
    wait_result(n);
    chk("sub_valid", out_valid, 1);
    chk("sub_y", out_y, 32'h40400000);
    chk("sub_tag", out_tag, 7);
    pop_one();

    // overflow
    send(32'h7f7fffff, 32'h7f7fffff, 1'b0, 5'd3);
    wait_result(n);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_y", out_y, 32'h7f800000);
    chk("ovf_flag", out_ovf, 1);
    pop_one();
`ifdef FADD_OVF_STICKY_EN
    chk("sticky_set", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);
`endif

    // backpressure: only FIFO_DEPTH credits
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_tag = TW'(i); in_x1 = 32'h40000000 | 32'(i); in_x2 = '0; in_sub = 1'b0;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, FD);
    chk("bp_in_ready", in_ready, 0);
    tick(); tick(); tick();
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_ready", in_ready, 0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < FD; c++) begin
      if (out_valid) begin
        chk("bp_tag", out_tag, got);
        chk("bp_y", out_y, 32'h40000000 | 32'(got));
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("bp_count", got, FD);
    chk("bp_empty", out_valid, 0);
    chk("bp_busy", busy, 0);

    // streaming with consumer always ready
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      in_valid = (sent < 20);
      in_tag = TW'(sent); in_x1 = 32'h41000000 | 32'(sent); in_x2 = '0; in_sub = 1'b0;
      if (out_valid) begin
        chk("stream_tag", out_tag, got);
        chk("stream_y", out_y, 32'h41000000 | 32'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, 20);
    tick(); tick();
    chk("stream_no_extra", out_valid, 0);
    chk("stream_busy", busy, 0);
    out_ready = 1'b0;

    // reset with two ops in flight, one cycle before the first result would appear
    in_valid = 1'b1; in_x1 = 32'h40400000; in_x2 = '0; in_sub = 1'b0; in_tag = 5'd1;
    tick();
    in_tag = 5'd2;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", seen, 0);
    chk("mid_rst_busy", busy, 0);
    send(32'h3f800000, 32'h40000000, 1'b0, 5'd9);
    wait_result(n);
    chk("post_rst_latency", n, LAT + 2);
    chk("post_rst_y", out_y, 32'h40400000);
    chk("post_rst_tag", out_tag, 9);
    pop_one();
    chk("post_rst_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
